filter_mem_arbiter: RTL and testbench

// - Shares the 3-lane 18-bit filter data memory between two requesters: the filterGPU pipeline

---
 rtl/filter_gpu_pkg.sv | 18 +
 rtl/mem_rsp_router.sv | 40 ++++
 rtl/filter_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_filter_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_gpu_pkg.sv
// Shared types for the filterGPU 3-lane, 18-bit data memory and its arbiter.
package filter_gpu_pkg;

  localparam int LANES  = 3;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;

  // Element [0] is lane0 (A1), [1] is lane1 (A2), [2] is lane2 (A3).
  typedef logic [LANES-1:0][ADDR_W-1:0] lane_addr_t;
  typedef logic [LANES-1:0][DATA_W-1:0] lane_data_t;

  // Memory owner. It is also used as the tag of an outstanding read.
  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_rsp_router.sv
// Routes registered memory read data to whichever requester issued the read.
// A one-bit tag records who issued the read. At most one rvalid is high in any cycle.
module mem_rsp_router
  import filter_gpu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       rd_accept_i,
  input  arb_state_t rd_owner_i,
  input  lane_data_t mem_rdata_i,
  output lane_data_t core_rdata_o,
  output logic       core_rvalid_o,
  output lane_data_t host_rdata_o,
  output logic       host_rvalid_o
);

  logic       rd_pending_q;
  arb_state_t rd_owner_q;

  // Capture the owner of a read accepted this cycle; memory returns its data next cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: sequential state uses <= so that every flop samples pre-edge values.
      rd_pending_q <= 1'b0;
      rd_owner_q   <= OWN_CORE;
    end else begin
      rd_pending_q <= rd_accept_i;
      rd_owner_q   <= rd_owner_i;
    end
  end

  // Steer the returning data. It reads as zero when no read is returning.
  always_comb begin
    core_rvalid_o = rd_pending_q && (rd_owner_q == OWN_CORE);
    host_rvalid_o = rd_pending_q && (rd_owner_q == OWN_HOST);
    core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: rtl/filter_mem_arbiter.sv
// Shares the filter data memory between the core MEM stage and the host loader.
// The core owns the memory by default and sees no added latency. The host gets bursts of
// up to BURST_MAX beats. A host request that waits MAX_WAIT cycles preempts the core.
module filter_mem_arbiter
  import filter_gpu_pkg::*;
#(
  parameter int BURST_MAX = 16,
  parameter int MAX_WAIT  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       core_req,
  input  logic       core_we,
  input  lane_addr_t core_addr,
  input  lane_data_t core_wdata,
  output logic       core_stall,
  output lane_data_t core_rdata,
  output logic       core_rvalid,
  input  logic       host_req,
  input  logic       host_we,
  input  lane_addr_t host_addr,
  input  lane_data_t host_wdata,
  input  logic       host_last,
  output logic       host_gnt,
  output lane_data_t host_rdata,
  output logic       host_rvalid,
  output lane_addr_t mem_addr,
  output logic       mem_we,
  output lane_data_t mem_wdata,
  input  lane_data_t mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              rd_accept;
  arb_state_t        rd_owner;

  // Ownership state and the starvation and burst counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= OWN_CORE;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic, handshakes, and the combinational memory mux for the current owner.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    core_stall = 1'b0;
    host_gnt   = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    rd_accept  = 1'b0;
    rd_owner   = OWN_CORE;

    unique case (state_q)
      OWN_CORE: begin
        beat_cnt_d = '0;
        if (core_req) begin
          mem_addr  = core_addr;
          mem_we    = core_we;
          mem_wdata = core_wdata;
          rd_accept = !core_we;
        end
        if (!host_req) begin
          wait_cnt_d = '0;
        end else if (!core_req) begin
          state_d    = OWN_HOST;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
          // The host has waited behind the core long enough, so it takes the next cycle.
          state_d    = OWN_HOST;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      OWN_HOST: begin
        core_stall = core_req;
        host_gnt   = host_req;
        wait_cnt_d = '0;
        if (host_req) begin
          mem_addr  = host_addr;
          mem_we    = host_we;
          mem_wdata = host_wdata;
          rd_accept = !host_we;
          rd_owner  = OWN_HOST;
          if (beat_cnt_q != BEAT_W'(BURST_MAX)) beat_cnt_d = beat_cnt_q + 1'b1;
          // The last beat and the burst limit both lead to the same single exit.
          if (host_last || beat_cnt_q == BEAT_W'(BURST_MAX - 1)) begin
            state_d    = OWN_CORE;
            beat_cnt_d = '0;
          end
        end else begin
          state_d    = OWN_CORE;
          beat_cnt_d = '0;
        end
      end

      default: begin
        state_d = OWN_CORE;
      end
    endcase
  end

  mem_rsp_router u_rsp_router (
    .CLK          (CLK),
    .RST          (RST),
    .rd_accept_i  (rd_accept),
    .rd_owner_i   (rd_owner),
    .mem_rdata_i  (mem_rdata),
    .core_rdata_o (core_rdata),
    .core_rvalid_o(core_rvalid),
    .host_rdata_o (host_rdata),
    .host_rvalid_o(host_rvalid)
  );

endmodule

// File: tb/tb_filter_mem_arbiter.sv
// Directed bench for filter_mem_arbiter. It has a behavioural latency-1 memory and a
// read-return scoreboard for each requester.
module tb_filter_mem_arbiter;
  import filter_gpu_pkg::*;

  localparam int BURST_MAX = 16;
  localparam int MAX_WAIT  = 8;
  localparam int DEPTH     = 1 << ADDR_W;

  logic       CLK = 1'b0;
  logic       RST;
  logic       core_req, core_we, host_req, host_we, host_last;
  lane_addr_t core_addr, host_addr, mem_addr;
  lane_data_t core_wdata, host_wdata, mem_wdata, mem_rdata;
  lane_data_t core_rdata, host_rdata;
  logic       core_stall, core_rvalid, host_gnt, host_rvalid, mem_we;

  int checks   = 0;
  int failures = 0;

  lane_data_t core_q[$];
  lane_data_t host_q[$];

  logic [DATA_W-1:0] mem_l [LANES][DEPTH];

  filter_mem_arbiter #(.BURST_MAX(BURST_MAX), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_last(host_last), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Behavioural memory with a registered, read-first port for each lane.
  always @(posedge CLK) begin
    for (int l = 0; l < LANES; l++) begin
      mem_rdata[l] <= mem_l[l][mem_addr[l]];
      if (mem_we) mem_l[l][mem_addr[l]] <= mem_wdata[l];
    end
  end

  function automatic lane_data_t init_val(input int a);
    lane_data_t v;
    for (int l = 0; l < LANES; l++) v[l] = DATA_W'(a * 4 + l + 1);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: each read return must match the oldest expectation for its requester.
  always @(negedge CLK) begin
    if (!RST) begin
      check("one_rvalid", core_rvalid & host_rvalid, 1'b0);
      if (core_rvalid) begin
        if (core_q.size() == 0) check("core_rvalid_unexpected", core_rvalid, 1'b0);
        else check("core_rdata", core_rdata, core_q.pop_front());
      end
      if (host_rvalid) begin
        if (host_q.size() == 0) check("host_rvalid_unexpected", host_rvalid, 1'b0);
        else check("host_rdata", host_rdata, host_q.pop_front());
      end
    end
  end

  // Present one host beat and hold it until it is granted. Returns the cycles spent waiting.
  task automatic host_beat(input logic we, input int a, input logic last, output int waited);
    lane_addr_t addr;
    lane_data_t data;
    for (int l = 0; l < LANES; l++) begin
      addr[l] = ADDR_W'(a);
      data[l] = DATA_W'(18'h20000 + a * 4 + l);
    end
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = data; host_last = last;
    waited = 0;
    forever begin
      @(negedge CLK);
      if (host_gnt) break;
      check("core_stall_while_core_owns", core_stall, 1'b0);
      waited++;
      if (waited >= 60) begin
        check("host_gnt_timeout", host_gnt, 1'b1);
        break;
      end
    end
    if (host_gnt) begin
      check("gnt_core_stall", core_stall, core_req);
      check("gnt_mem_addr", mem_addr, addr);
      check("gnt_mem_we", mem_we, we);
      if (we) check("gnt_mem_wdata", mem_wdata, data);
      else host_q.push_back(init_val(a));
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    lane_data_t exp;
    for (int a = 0; a < DEPTH; a++) begin
      exp = init_val(a);
      for (int l = 0; l < LANES; l++) mem_l[l][a] = exp[l];
    end
    mem_l[0][5] = 18'd1; mem_l[1][6] = 18'd2; mem_l[2][7] = 18'd3;

    RST = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_last = 1'b0;

    // Reset values.
    @(negedge CLK);
    check("rst_host_gnt", host_gnt, 1'b0);
    check("rst_core_rvalid", core_rvalid, 1'b0);
    check("rst_host_rvalid", host_rvalid, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_core_stall", core_stall, 1'b0);
    check("rst_core_rdata", core_rdata, 54'd0);
    tick(); tick();
    RST = 1'b0;
    tick();

    // Core only: load {5,6,7} should return {1,2,3} one cycle later.
    core_req = 1'b1; core_we = 1'b0;
    for (int l = 0; l < LANES; l++) core_addr[l] = ADDR_W'(5 + l);
    @(negedge CLK);
    check("core_ld_stall", core_stall, 1'b0);
    check("core_ld_mem_addr", mem_addr, core_addr);
    check("core_ld_mem_we", mem_we, 1'b0);
    check("core_ld_host_gnt", host_gnt, 1'b0);
    exp[0] = 18'd1; exp[1] = 18'd2; exp[2] = 18'd3;
    core_q.push_back(exp);
    tick();
    core_req = 1'b0;
    @(negedge CLK);
    check("core_ld_rvalid", core_rvalid, 1'b1);
    check("idle_mem_we", mem_we, 1'b0);
    check("idle_mem_addr", mem_addr, 30'd0);
    check("idle_mem_wdata", mem_wdata, 54'd0);
    tick();

    // Core store then load back from the same addresses.
    core_req = 1'b1; core_we = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      core_addr[l]  = ADDR_W'(10);
      core_wdata[l] = DATA_W'(100 * (l + 1));
    end
    @(negedge CLK);
    check("core_st_mem_we", mem_we, 1'b1);
    check("core_st_mem_wdata", mem_wdata, core_wdata);
    check("core_st_stall", core_stall, 1'b0);
    tick();
    core_we = 1'b0;
    exp[0] = 18'd100; exp[1] = 18'd200; exp[2] = 18'd300;
    core_q.push_back(exp);
    @(negedge CLK);
    check("core_st_no_rvalid", core_rvalid, 1'b0);
    tick();
    core_req = 1'b0;
    @(negedge CLK);
    check("core_ldback_rvalid", core_rvalid, 1'b1);
    tick();

    // Host 4-beat read burst while the core is idle.
    for (int i = 0; i < 4; i++) begin
      host_beat(1'b0, 20 + i, (i == 3), w);
      check($sformatf("burst4_wait_%0d", i), w, (i == 0) ? 1 : 0);
    end
    host_last = 1'b0; host_addr = '0;
    @(negedge CLK);
    check("burst4_exit_gnt", host_gnt, 1'b0);
    check("burst4_exit_state", dut.state_q, OWN_CORE);
    tick();
    host_req = 1'b0;
    @(negedge CLK);
    check("burst4_reentry_req_low_gnt", host_gnt, 1'b0);
    tick(); tick();

    // Starvation: core stores continuously, and a single host read must wait MAX_WAIT cycles.
    core_req = 1'b1; core_we = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      core_addr[l]  = ADDR_W'(900);
      core_wdata[l] = DATA_W'(7);
    end
    host_beat(1'b0, 30, 1'b1, w);
    check("starve_wait", w, MAX_WAIT);
    host_req = 1'b0; host_last = 1'b0;
    @(negedge CLK);
    check("starve_core_back_stall", core_stall, 1'b0);
    check("starve_core_back_we", mem_we, 1'b1);
    check("starve_core_back_addr", mem_addr, core_addr);
    tick();

    // Burst limit: 20 host beats without host_last while the core keeps requesting.
    for (int i = 0; i < 20; i++) begin
      host_beat(1'b0, 40 + i, 1'b0, w);
      if (i == 0) check("limit_wait_first", w, MAX_WAIT);
      else if (i == BURST_MAX) check("limit_resume_within_max_wait", (w >= 1 && w <= MAX_WAIT), 1'b1);
      else check($sformatf("limit_wait_%0d", i), w, 0);
    end
    host_req = 1'b0;
    @(negedge CLK);
    check("limit_req_low_gnt", host_gnt, 1'b0);
    check("limit_req_low_stall", core_stall, 1'b1);
    tick();
    @(negedge CLK);
    check("limit_core_back_stall", core_stall, 1'b0);
    tick();
    core_req = 1'b0; core_we = 1'b0;
    tick();

    // Read straddling an ownership switch: host read on the final beat, core load next cycle.
    host_beat(1'b0, 70, 1'b0, w);
    host_beat(1'b0, 71, 1'b1, w);
    host_req = 1'b0; host_last = 1'b0;
    core_req = 1'b1; core_we = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      core_addr[l] = ADDR_W'(80 + l);
      exp[l] = DATA_W'((80 + l) * 4 + l + 1);
    end
    core_q.push_back(exp);
    @(negedge CLK);
    check("straddle_host_rvalid", host_rvalid, 1'b1);
    check("straddle_core_rvalid_early", core_rvalid, 1'b0);
    check("straddle_core_stall", core_stall, 1'b0);
    tick();
    core_req = 1'b0;
    @(negedge CLK);
    check("straddle_core_rvalid", core_rvalid, 1'b1);
    check("straddle_host_rvalid_late", host_rvalid, 1'b0);
    tick();

    // Reset asserted in the middle of beat 3 of an 8-beat host burst.
    host_beat(1'b1, 60, 1'b0, w);
    host_beat(1'b1, 61, 1'b0, w);
    host_we = 1'b0;
    for (int l = 0; l < LANES; l++) host_addr[l] = ADDR_W'(62);
    #1;
    check("rst_mid_pre_gnt", host_gnt, 1'b1);
    RST = 1'b1;
    #1;
    check("rst_mid_host_gnt", host_gnt, 1'b0);
    check("rst_mid_mem_we", mem_we, 1'b0);
    check("rst_mid_core_stall", core_stall, 1'b0);
    check("rst_mid_host_rvalid", host_rvalid, 1'b0);
    check("rst_mid_host_rdata", host_rdata, 54'd0);
    check("rst_mid_state", dut.state_q, OWN_CORE);
    host_req = 1'b0;
    tick(); tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("post_rst_host_rvalid", host_rvalid, 1'b0);
      check("post_rst_core_rvalid", core_rvalid, 1'b0);
      check("post_rst_state", dut.state_q, OWN_CORE);
      tick();
    end

    check("core_q_drained", core_q.size(), 0);
    check("host_q_drained", host_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
